// File: rtl/nn_feeder.sv
`default_nettype none
// ============================================================================
// Module      : nn_feeder
// Description : Buffers host-written samples (two ping-pong slots) and weight
//               sets, then replays them to the NN block over its
//               in_valid_d/t/w1/w2 stream interface. A new weight set is sent
//               before the next sample; each sample waits for NN out_valid.
//               Optional WAIT_OUT timeout enabled by macro FEEDER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_feeder #(
  parameter int DW          = 32,
  parameter int D_N         = 8,
  parameter int W1_N        = 24,
  parameter int W2_N        = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,          // active-high asynchronous reset
  input  logic          wr_valid,
  input  logic [1:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          nn_out_valid,
  output logic          in_valid_d,
  output logic          in_valid_t,
  output logic          in_valid_w1,
  output logic          in_valid_w2,
  output logic [DW-1:0] data_point,
  output logic [DW-1:0] target,
  output logic [DW-1:0] weight1,
  output logic [DW-1:0] weight2,
  output logic          busy,
  output logic [15:0]   done_cnt,
  output logic          err
);

  localparam int DC_W  = $clog2(D_N + 1);
  localparam int DI_W  = (D_N > 1) ? $clog2(D_N) : 1;
  localparam int W1C_W = $clog2(W1_N + 1);
  localparam int W1I_W = (W1_N > 1) ? $clog2(W1_N) : 1;
  localparam int W2C_W = $clog2(W2_N + 1);
  localparam int W2I_W = (W2_N > 1) ? $clog2(W2_N) : 1;
  localparam int SQ_N  = (W1_N > D_N) ? W1_N : D_N;
  localparam int SQ_W  = (SQ_N > 1) ? $clog2(SQ_N) : 1;

  localparam logic [1:0] SEL_D  = 2'd0;
  localparam logic [1:0] SEL_T  = 2'd1;
  localparam logic [1:0] SEL_W1 = 2'd2;

  localparam logic [DC_W-1:0]  D_FULL  = DC_W'(D_N);
  localparam logic [W1C_W-1:0] W1_FULL = W1C_W'(W1_N);
  localparam logic [W2C_W-1:0] W2_FULL = W2C_W'(W2_N);
  localparam logic [SQ_W-1:0]  W1_LAST = SQ_W'(W1_N - 1);
  localparam logic [SQ_W-1:0]  D_LAST  = SQ_W'(D_N - 1);
  localparam logic [SQ_W-1:0]  W2_LIM  = SQ_W'(W2_N);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_W   = 2'd1,
    SEND_D   = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  // Buffer storage (not reset; validity is tracked by counts and flags)
  logic [DW-1:0] d_mem_q  [2][D_N];
  logic [DW-1:0] t_mem_q  [2];
  logic [DW-1:0] w1_mem_q [W1_N];
  logic [DW-1:0] w2_mem_q [W2_N];

  // Fill-side state
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic             t_have_q, t_have_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       slot_full_q, slot_full_d;
  logic [W1C_W-1:0] w1cnt_q, w1cnt_d;
  logic [W2C_W-1:0] w2cnt_q, w2cnt_d;
  logic             wgt_pending_q, wgt_pending_d;
  logic             wgt_loaded_q, wgt_loaded_d;

  // Replay-side state
  state_t           state_q, state_d;
  logic [SQ_W-1:0]  idx_q, idx_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [15:0]      done_cnt_q, done_cnt_d;
  logic             in_valid_d_q, in_valid_d_d;
  logic             in_valid_t_q, in_valid_t_d;
  logic             in_valid_w1_q, in_valid_w1_d;
  logic             in_valid_w2_q, in_valid_w2_d;
  logic [DW-1:0]    data_point_q, data_point_d;
  logic [DW-1:0]    target_q, target_d;
  logic [DW-1:0]    weight1_q, weight1_d;
  logic [DW-1:0]    weight2_q, weight2_d;

  // Cross-process strobes
  logic wr_d_en, wr_t_en, wr_w1_en, wr_w2_en;
  logic sample_commit, wgt_commit;
  logic slot_rel, wgt_sent;

`ifdef FEEDER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  // Write acceptance and fill-side bookkeeping (counts, commits, slot flags)
  always_comb begin
    case (wr_sel)
      SEL_D:   wr_ready = (dcnt_q != D_FULL) && !slot_full_q[wr_ptr_q];
      SEL_T:   wr_ready = !t_have_q && !slot_full_q[wr_ptr_q];
      SEL_W1:  wr_ready = (state_q != SEND_W) && (w1cnt_q != W1_FULL);
      default: wr_ready = (state_q != SEND_W) && (w2cnt_q != W2_FULL);
    endcase
    wr_d_en  = wr_valid && wr_ready && (wr_sel == SEL_D);
    wr_t_en  = wr_valid && wr_ready && (wr_sel == SEL_T);
    wr_w1_en = wr_valid && wr_ready && (wr_sel == SEL_W1);
    wr_w2_en = wr_valid && wr_ready && (wr_sel == 2'd3);

    // Commits fire one cycle after the last piece lands; writes are blocked meanwhile
    sample_commit = (dcnt_q == D_FULL) && t_have_q;
    wgt_commit    = (w1cnt_q == W1_FULL) && (w2cnt_q == W2_FULL);

    dcnt_d   = dcnt_q;
    t_have_d = t_have_q;
    wr_ptr_d = wr_ptr_q;
    if (sample_commit) begin
      dcnt_d   = '0;
      t_have_d = 1'b0;
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      if (wr_d_en) dcnt_d = dcnt_q + 1'b1;
      if (wr_t_en) t_have_d = 1'b1;
    end

    w1cnt_d = w1cnt_q;
    w2cnt_d = w2cnt_q;
    if (wgt_commit) begin
      w1cnt_d = '0;
      w2cnt_d = '0;
    end else begin
      if (wr_w1_en) w1cnt_d = w1cnt_q + 1'b1;
      if (wr_w2_en) w2cnt_d = w2cnt_q + 1'b1;
    end

    // Release and commit always address different slots, so both may apply
    slot_full_d = slot_full_q;
    if (slot_rel)      slot_full_d[rd_ptr_q] = 1'b0;
    if (sample_commit) slot_full_d[wr_ptr_q] = 1'b1;

    wgt_pending_d = (wgt_pending_q && !wgt_sent) || wgt_commit;
    wgt_loaded_d  = wgt_loaded_q || wgt_sent;
  end

  // Host writes into the buffers
  always_ff @(posedge clk) begin
    if (wr_d_en)  d_mem_q[wr_ptr_q][dcnt_q[DI_W-1:0]] <= wr_data;
    if (wr_t_en)  t_mem_q[wr_ptr_q] <= wr_data;
    if (wr_w1_en) w1_mem_q[w1cnt_q[W1I_W-1:0]] <= wr_data;
    if (wr_w2_en) w2_mem_q[w2cnt_q[W2I_W-1:0]] <= wr_data;
  end

  // Replay FSM: next state, and stream outputs derived from the next state so
  // the registered valids line up with the state they belong to
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rd_ptr_d      = rd_ptr_q;
    done_cnt_d    = done_cnt_q;
    slot_rel      = 1'b0;
    wgt_sent      = 1'b0;
    in_valid_d_d  = 1'b0;
    in_valid_t_d  = 1'b0;
    in_valid_w1_d = 1'b0;
    in_valid_w2_d = 1'b0;
    data_point_d  = '0;
    target_d      = '0;
    weight1_d     = '0;
    weight2_d     = '0;
`ifdef FEEDER_TIMEOUT_EN
    to_cnt_d      = '0;
    err_d         = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Weights take priority; samples never go out before a first weight set
        if (wgt_pending_q) begin
          state_d = SEND_W;
          idx_d   = '0;
        end else if (wgt_loaded_q && slot_full_q[rd_ptr_q]) begin
          state_d = SEND_D;
          idx_d   = '0;
        end
      end
      SEND_W: begin
        if (idx_q == W1_LAST) begin
          state_d  = IDLE;
          wgt_sent = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND_D: begin
        if (idx_q == D_LAST) state_d = WAIT_OUT;
        else                 idx_d   = idx_q + 1'b1;
      end
      default: begin
        if (nn_out_valid) begin
          slot_rel   = 1'b1;
          rd_ptr_d   = ~rd_ptr_q;
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = IDLE;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Give up on this sample: free its slot without counting it
          err_d    = 1'b1;
          slot_rel = 1'b1;
          rd_ptr_d = ~rd_ptr_q;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
    endcase

    if (state_d == SEND_W) begin
      in_valid_w1_d = 1'b1;
      weight1_d     = w1_mem_q[idx_d[W1I_W-1:0]];
      if (idx_d < W2_LIM) begin
        in_valid_w2_d = 1'b1;
        weight2_d     = w2_mem_q[idx_d[W2I_W-1:0]];
      end
    end
    if (state_d == SEND_D) begin
      in_valid_d_d = 1'b1;
      data_point_d = d_mem_q[rd_ptr_d][idx_d[DI_W-1:0]];
      if (idx_d == '0) begin
        in_valid_t_d = 1'b1;
        target_d     = t_mem_q[rd_ptr_d];
      end
    end
  end

  // Control and output registers; reset drops any stream in flight
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dcnt_q        <= '0;
      t_have_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      slot_full_q   <= '0;
      w1cnt_q       <= '0;
      w2cnt_q       <= '0;
      wgt_pending_q <= 1'b0;
      wgt_loaded_q  <= 1'b0;
      state_q       <= IDLE;
      idx_q         <= '0;
      rd_ptr_q      <= 1'b0;
      done_cnt_q    <= '0;
      in_valid_d_q  <= 1'b0;
      in_valid_t_q  <= 1'b0;
      in_valid_w1_q <= 1'b0;
      in_valid_w2_q <= 1'b0;
      data_point_q  <= '0;
      target_q      <= '0;
      weight1_q     <= '0;
      weight2_q     <= '0;
`ifdef FEEDER_TIMEOUT_EN
      to_cnt_q      <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      dcnt_q        <= dcnt_d;
      t_have_q      <= t_have_d;
      wr_ptr_q      <= wr_ptr_d;
      slot_full_q   <= slot_full_d;
      w1cnt_q       <= w1cnt_d;
      w2cnt_q       <= w2cnt_d;
      wgt_pending_q <= wgt_pending_d;
      wgt_loaded_q  <= wgt_loaded_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      rd_ptr_q      <= rd_ptr_d;
      done_cnt_q    <= done_cnt_d;
      in_valid_d_q  <= in_valid_d_d;
      in_valid_t_q  <= in_valid_t_d;
      in_valid_w1_q <= in_valid_w1_d;
      in_valid_w2_q <= in_valid_w2_d;
      data_point_q  <= data_point_d;
      target_q      <= target_d;
      weight1_q     <= weight1_d;
      weight2_q     <= weight2_d;
`ifdef FEEDER_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign in_valid_d  = in_valid_d_q;
  assign in_valid_t  = in_valid_t_q;
  assign in_valid_w1 = in_valid_w1_q;
  assign in_valid_w2 = in_valid_w2_q;
  assign data_point  = data_point_q;
  assign target      = target_q;
  assign weight1     = weight1_q;
  assign weight2     = weight2_q;
  assign done_cnt    = done_cnt_q;
  assign busy        = (state_q != IDLE);
`ifdef FEEDER_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nn_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_feeder
// Description : Scoreboard bench for nn_feeder. Host writes push expected
//               stream words; a negedge monitor pops and compares them and
//               checks stream framing (lengths, w2/t positions, zeroed data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_feeder;
  localparam int DW     = 32;
  localparam int D_N    = 8;
  localparam int W1_N   = 24;
  localparam int W2_N   = 3;
  localparam int TO_CYC = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [1:0]    wr_sel = 2'd0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          nn_out_valid = 1'b0;
  logic          in_valid_d, in_valid_t, in_valid_w1, in_valid_w2;
  logic [DW-1:0] data_point, target, weight1, weight2;
  logic          busy;
  logic [15:0]   done_cnt;
  logic          err;

  always #5 clk = ~clk;

  nn_feeder #(
    .DW(DW), .D_N(D_N), .W1_N(W1_N), .W2_N(W2_N), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ready(wr_ready),
    .nn_out_valid(nn_out_valid),
    .in_valid_d(in_valid_d), .in_valid_t(in_valid_t),
    .in_valid_w1(in_valid_w1), .in_valid_w2(in_valid_w2),
    .data_point(data_point), .target(target), .weight1(weight1), .weight2(weight2),
    .busy(busy), .done_cnt(done_cnt), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_d[$], exp_t[$], exp_w1[$], exp_w2[$];
  int   exp_done = 0;

  int cyc = 0;
  int w_run = 0, d_run = 0, w_runs = 0, d_runs = 0, d_beats = 0;
  int last_w_cyc = 0, first_d_cyc = 0;
  logic prev_w = 1'b0, prev_d = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: pops the scoreboard and checks framing on every negedge
  always @(negedge clk) begin
    if (rst_n) begin
      w_run = 0; d_run = 0; prev_w = 1'b0; prev_d = 1'b0;
    end else begin
      if (in_valid_w1) begin
        chk("w2_valid_pos", in_valid_w2, (w_run < W2_N));
        if (exp_w1.size() == 0) chk("w1_unexpected", 1, 0);
        else                    chk("weight1", weight1, exp_w1.pop_front());
        if (in_valid_w2) begin
          if (exp_w2.size() == 0) chk("w2_unexpected", 1, 0);
          else                    chk("weight2", weight2, exp_w2.pop_front());
        end
        w_run++;
        last_w_cyc = cyc;
      end else begin
        chk("w2_orphan", in_valid_w2, 0);
        chk("weight1_idle", weight1, 0);
        if (prev_w) begin
          chk("w1_len", w_run, W1_N);
          w_runs++;
          w_run = 0;
        end
      end
      if (!in_valid_w2) chk("weight2_idle", weight2, 0);

      if (in_valid_d) begin
        chk("t_valid_pos", in_valid_t, (d_run == 0));
        if (d_run == 0) first_d_cyc = cyc;
        if (exp_d.size() == 0) chk("d_unexpected", 1, 0);
        else                   chk("data_point", data_point, exp_d.pop_front());
        if (in_valid_t) begin
          if (exp_t.size() == 0) chk("t_unexpected", 1, 0);
          else                   chk("target", target, exp_t.pop_front());
        end
        d_run++;
        d_beats++;
      end else begin
        chk("t_orphan", in_valid_t, 0);
        chk("data_idle", data_point, 0);
        if (prev_d) begin
          chk("d_len", d_run, D_N);
          d_runs++;
          d_run = 0;
        end
      end
      if (!in_valid_t) chk("target_idle", target, 0);
      prev_w = in_valid_w1;
      prev_d = in_valid_d;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One host write; the expected stream word is queued once the DUT accepts it
  task automatic wr(input logic [1:0] sel, input logic [DW-1:0] val);
    int k = 0;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_sel = sel; wr_data = val;
    @(negedge clk);
    while (!wr_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!wr_ready) begin
      chk("wr_stall", 0, 1);
    end else begin
      case (sel)
        2'd0:    exp_d.push_back(val);
        2'd1:    exp_t.push_back(val);
        2'd2:    exp_w1.push_back(val);
        default: exp_w2.push_back(val);
      endcase
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic write_weights(input logic [DW-1:0] b1, input logic [DW-1:0] b2);
    for (int i = 0; i < W1_N; i++) wr(2'd2, b1 + DW'(i));
    for (int i = 0; i < W2_N; i++) wr(2'd3, b2 + DW'(i));
  endtask

  task automatic write_sample(input logic [DW-1:0] b, input logic [DW-1:0] tgt);
    for (int i = 0; i < D_N; i++) wr(2'd0, b + DW'(i));
    wr(2'd1, tgt);
  endtask

  task automatic wait_d(input int n);
    int k = 0;
    while (d_runs < n && k < 3000) begin step(); k++; end
    chk("d_run_wait", (d_runs >= n), 1);
  endtask

  task automatic wait_w(input int n);
    int k = 0;
    while (w_runs < n && k < 3000) begin step(); k++; end
    chk("w_run_wait", (w_runs >= n), 1);
  endtask

  task automatic pulse_out(input bit counted);
    @(posedge clk); #1 nn_out_valid = 1'b1;
    @(posedge clk); #1 nn_out_valid = 1'b0;
    if (counted) exp_done++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    exp_d.delete(); exp_t.delete(); exp_w1.delete(); exp_w2.delete();
    exp_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, w0, k;
    // ---- reset idle ----
    do_reset();
    step();
    chk("rst_valids", {in_valid_d, in_valid_t, in_valid_w1, in_valid_w2}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_cnt, 0);
    chk("rst_err", err, 0);
    for (int s = 0; s < 4; s++) begin
      wr_sel = 2'(s); #1;
      chk("rst_wr_ready", wr_ready, 1);
    end
    pulse_out(0);
    step();
    chk("idle_pulse_ignored", done_cnt, 0);

    // ---- weights then sample ----
    write_weights(32'h3F800000, 32'hBF000000);
    wait_w(1);
    write_sample(32'h41000000, 32'h40000000);
    wait_d(1);
    chk("wait_busy", busy, 1);
    chk("wait_done", done_cnt, 0);
    pulse_out(1);
    step();
    chk("done_after_1", done_cnt, 16'(exp_done));
    chk("busy_after_1", busy, 0);

    // ---- sample before weights ----
    do_reset();
    d0 = d_beats;
    write_sample(32'h42000000, 32'h3F000000);
    repeat (40) step();
    chk("no_d_without_w", d_beats, d0);
    chk("idle_without_w", busy, 0);
    w0 = w_runs;
    write_weights(32'h3E000000, 32'h3D000000);
    wait_w(w0 + 1);
    d0 = d_runs;
    wait_d(d0 + 1);
    chk("w_to_d_gap", first_d_cyc - last_w_cyc, 2);
    pulse_out(1);
    step();
    chk("done_after_late_w", done_cnt, 16'(exp_done));

    // ---- ping-pong backpressure ----
    d0 = d_runs;
    write_sample(32'h43000000, 32'h44000000);
    write_sample(32'h45000000, 32'h46000000);
    wait_d(d0 + 1);
    repeat (3) step();
    chk("second_held", d_runs, d0 + 1);
    wr_sel = 2'd0; #1;
    chk("bp_ready_data", wr_ready, 0);
    wr_sel = 2'd1; #1;
    chk("bp_ready_tgt", wr_ready, 0);
    wr_sel = 2'd2; #1;
    chk("bp_ready_w1", wr_ready, 1);
    wr_sel = 2'd0;
    pulse_out(1);
    chk("bp_ready_after", wr_ready, 1);
    wait_d(d0 + 2);
    chk("done_after_a", done_cnt, 16'(exp_done));
    // new weight set and sample arrive while NN still owes an answer
    w0 = w_runs;
    write_weights(32'h3C000000, 32'h3B000000);
    write_sample(32'h47000000, 32'h48000000);
    chk("held_in_wait", d_runs, d0 + 2);
    pulse_out(1);
    wait_d(d0 + 3);
    chk("new_w_sent", w_runs, w0 + 1);
    chk("w_before_d_gap", first_d_cyc - last_w_cyc, 2);
    pulse_out(1);
    step();
    chk("done_after_c", done_cnt, 16'(exp_done));

    // ---- mid-stream reset ----
    write_sample(32'h49000000, 32'h4A000000);
    k = 0;
    while (d_run < 4 && k < 500) begin step(); k++; end
    chk("reach_d_cycle4", d_run, 4);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("mid_rst_valid_d", in_valid_d, 0);
    chk("mid_rst_data", data_point, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_cnt, 0);
    exp_d.delete(); exp_t.delete(); exp_w1.delete(); exp_w2.delete();
    exp_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    step();
    wr_sel = 2'd0; #1;
    chk("post_rst_ready", wr_ready, 1);
    d0 = d_beats;
    w0 = w_runs;
    write_weights(32'h3A000000, 32'h39000000);
    wait_w(w0 + 1);
    repeat (10) step();
    chk("slots_empty", d_beats, d0);
    d0 = d_runs;
    write_sample(32'h4B000000, 32'h4C000000);
    wait_d(d0 + 1);

    // ---- WAIT_OUT with no answer from NN ----
`ifdef FEEDER_TIMEOUT_EN
    repeat (14) step();
    chk("to_err_early", err, 0);
    chk("to_busy_early", busy, 1);
    repeat (4) step();
    chk("to_err_set", err, 1);
    chk("to_busy_freed", busy, 0);
    chk("to_done_same", done_cnt, 16'(exp_done));
    write_sample(32'h4D000000, 32'h4E000000);
    write_sample(32'h4F000000, 32'h50000000);
    wait_d(d0 + 2);
    pulse_out(1);
    wait_d(d0 + 3);
    pulse_out(1);
    step();
    chk("to_done_after", done_cnt, 16'(exp_done));
    chk("to_err_sticky", err, 1);
`else
    repeat (40) step();
    chk("no_to_err", err, 0);
    chk("no_to_busy", busy, 1);
    chk("no_to_done", done_cnt, 16'(exp_done));
    pulse_out(1);
    step();
    chk("no_to_done_after", done_cnt, 16'(exp_done));
`endif

    repeat (5) step();
    chk("left_d", exp_d.size(), 0);
    chk("left_t", exp_t.size(), 0);
    chk("left_w1", exp_w1.size(), 0);
    chk("left_w2", exp_w2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
